mc_status_display: RTL and testbench

Display decoder for the multi-cycle CPU controller's status outputs. It accepts the controller's 4-bit `state`, `insn_type`, `insn_code` and 3-bit `insn_stage` codes and drives a 4-digit, time-multiplexed, active-low 7-segment display. It also counts retired instructions. It sits between the controller and the board display pins, and takes no input from the datapath.

---
 rtl/mc_status_display.sv | 141 ++++++++++++++
 tb/tb_mc_status_display.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_status_display.sv
// Status display for the multi-cycle CPU controller: snapshots the controller
// status once per scan frame and drives a 4-digit, active-low, time-multiplexed
// 7-segment display. Also counts retired instructions (stage returning to IF).
module mc_status_display #(
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] state,
   input  logic [3:0] insn_type,
   input  logic [3:0] insn_code,
   input  logic [2:0] insn_stage,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic [7:0] retire_cnt
);

   localparam logic [15:0] SCAN_LAST   = 16'(SCAN_DIV - 1);
   localparam logic [7:0]  FRAME_LAST  = 8'(BLINK_FRAMES - 1);
   localparam logic [6:0]  GLYPH_DASH  = 7'b0111111;
   localparam logic [6:0]  GLYPH_BLANK = 7'b1111111;

   logic [15:0] scan_cnt;
   logic [1:0]  idx;
   logic [7:0]  frame_cnt;
   logic        blink;
   logic [3:0]  snap_state;
   logic [3:0]  snap_type;
   logic [3:0]  snap_code;
   logic [2:0]  snap_stage;
   logic        digit_end;
   logic        frame_end;
   logic [3:0]  digit_val;
   logic        digit_ok;
   logic [6:0]  glyph;

   assign digit_end = (scan_cnt == SCAN_LAST);
   assign frame_end = digit_end && (idx == 2'd3);

   function automatic logic [6:0] hex_glyph(input logic [3:0] v);
      case (v)
         4'h0:    hex_glyph = 7'b1000000;
         4'h1:    hex_glyph = 7'b1111001;
         4'h2:    hex_glyph = 7'b0100100;
         4'h3:    hex_glyph = 7'b0110000;
         4'h4:    hex_glyph = 7'b0011001;
         4'h5:    hex_glyph = 7'b0010010;
         4'h6:    hex_glyph = 7'b0000010;
         4'h7:    hex_glyph = 7'b1111000;
         4'h8:    hex_glyph = 7'b0000000;
         4'h9:    hex_glyph = 7'b0010000;
         4'hA:    hex_glyph = 7'b0001000;
         4'hB:    hex_glyph = 7'b0000011;
         4'hC:    hex_glyph = 7'b1000110;
         4'hD:    hex_glyph = 7'b0100001;
         4'hE:    hex_glyph = 7'b0000110;
         default: hex_glyph = 7'b0001110;
      endcase
   endfunction

   // Per-digit dwell counter and digit index; idx advances on each dwell wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt <= '0;
         idx      <= '0;
      end else if (digit_end) begin
         scan_cnt <= '0;
         idx      <= idx + 2'd1;
      end else begin
         scan_cnt <= scan_cnt + 16'd1;
      end
   end

   // Frame-boundary work: snapshot load, retire detection and blink timebase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_state <= '0;
         snap_type  <= '0;
         snap_code  <= '0;
         snap_stage <= '0;
         retire_cnt <= '0;
         frame_cnt  <= '0;
         blink      <= 1'b1;
      end else if (frame_end) begin
         snap_state <= state;
         snap_type  <= insn_type;
         snap_code  <= insn_code;
         snap_stage <= insn_stage;
         // A retire is any transition from a non-IF stage (valid or not) back to IF.
         if (snap_stage != 3'd0 && insn_stage == 3'd0)
            retire_cnt <= retire_cnt + 8'd1;
         if (frame_cnt == FRAME_LAST) begin
            frame_cnt <= '0;
            blink     <= ~blink;
         end else begin
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

   // Select the snapshot field for the current digit and decide its glyph.
   always_comb begin
      digit_val = snap_state;
      digit_ok  = 1'b1;
      case (idx)
         2'd0: begin
            digit_val = snap_state;
            digit_ok  = 1'b1;
         end
         2'd1: begin
            digit_val = {1'b0, snap_stage};
            digit_ok  = (snap_stage <= 3'd4);
         end
         2'd2: begin
            digit_val = snap_code;
            digit_ok  = (snap_code <= 4'd7);
         end
         default: begin
            digit_val = snap_type;
            digit_ok  = (snap_type <= 4'd3);
         end
      endcase
      glyph = digit_ok ? hex_glyph(digit_val) : (blink ? GLYPH_DASH : GLYPH_BLANK);
   end

   // Registered pin drivers, one cycle behind idx.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an  <= 4'b1111;
         seg <= GLYPH_BLANK;
         dp  <= 1'b1;
      end else begin
         an  <= ~(4'b0001 << idx);
         seg <= glyph;
         dp  <= ~((idx == 2'd0) && retire_cnt[0]);
      end
   end

endmodule

// File: tb/tb_mc_status_display.sv
// Self-checking bench for mc_status_display with a frame-level reference model.
module tb_mc_status_display;

   localparam int SD    = 4;
   localparam int BF    = 2;
   localparam int FRAME = 4 * SD;
   localparam logic [6:0] DASH  = 7'b0111111;
   localparam logic [6:0] BLANK = 7'b1111111;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] state = '0;
   logic [3:0] insn_type = '0;
   logic [3:0] insn_code = '0;
   logic [2:0] insn_stage = '0;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic [7:0] retire_cnt;

   int errors = 0;
   int checks = 0;

   // Model: positions elapsed since reset release, latched frame fields, retire count.
   int         cyc;
   logic [3:0] m_state, m_type, m_code;
   logic [2:0] m_stage;
   logic [7:0] m_retire;
   logic [3:0] exp_an;
   logic [6:0] exp_seg;
   logic       exp_dp;
   logic [7:0] exp_ret;
   int         cur_d;

   mc_status_display #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
      .clk(clk), .rst(rst), .state(state), .insn_type(insn_type),
      .insn_code(insn_code), .insn_stage(insn_stage),
      .an(an), .seg(seg), .dp(dp), .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] ref_glyph(input int v);
      case (v)
         0: return 7'b1000000;   1: return 7'b1111001;
         2: return 7'b0100100;   3: return 7'b0110000;
         4: return 7'b0011001;   5: return 7'b0010010;
         6: return 7'b0000010;   7: return 7'b1111000;
         8: return 7'b0000000;   9: return 7'b0010000;
         10: return 7'b0001000;  11: return 7'b0000011;
         12: return 7'b1000110;  13: return 7'b0100001;
         14: return 7'b0000110;  default: return 7'b0001110;
      endcase
   endfunction

   task automatic model_reset();
      cyc = 0; m_state = '0; m_type = '0; m_code = '0; m_stage = '0; m_retire = '0;
   endtask

   // Advance one clock and compute what the pins must show after this edge.
   task automatic tick();
      int  p, f, v;
      logic ok, blk;
      @(posedge clk);
      p     = cyc;
      f     = p / FRAME;
      cur_d = (p / SD) % 4;
      blk   = ((f / BF) % 2) == 0;
      case (cur_d)
         0: begin v = int'(m_state); ok = 1'b1; end
         1: begin v = int'(m_stage); ok = (m_stage < 5); end
         2: begin v = int'(m_code);  ok = (m_code < 8); end
         default: begin v = int'(m_type); ok = (m_type < 4); end
      endcase
      exp_an  = 4'b1111;
      exp_an[cur_d] = 1'b0;
      exp_seg = ok ? ref_glyph(v) : (blk ? DASH : BLANK);
      exp_dp  = !(cur_d == 0 && (m_retire % 2) == 1);
      if (p % FRAME == FRAME - 1) begin
         if (m_stage != 0 && insn_stage == 0) m_retire = m_retire + 8'd1;
         m_state = state; m_type = insn_type; m_code = insn_code; m_stage = insn_stage;
      end
      exp_ret = m_retire;
      cyc++;
      #1;
   endtask

   task automatic test_reset();
      logic [3:0] order [4];
      order[0] = 4'b1110; order[1] = 4'b1101; order[2] = 4'b1011; order[3] = 4'b0111;
      state = '0; insn_type = '0; insn_code = '0; insn_stage = '0;
      @(negedge clk); rst = 1'b1; #1;
      checks++;
      if ({an, seg, dp, retire_cnt} !== {4'b1111, 7'b1111111, 1'b1, 8'd0}) begin
         errors++;
         $display("FAIL reset_values an=%b seg=%b dp=%b ret=%0d want 1111/1111111/1/0", an, seg, dp, retire_cnt);
      end
      @(negedge clk); rst = 1'b0; model_reset();
      for (int k = 0; k < 2 * FRAME; k++) begin
         tick();
         checks++;
         if (an !== order[(k / SD) % 4] || seg !== 7'b1000000) begin
            errors++;
            $display("FAIL scan_order k=%0d an=%b seg=%b want %b/1000000", k, an, seg, order[(k / SD) % 4]);
         end
         checks++;
         if ({an, seg, dp, retire_cnt} !== {exp_an, exp_seg, exp_dp, exp_ret}) begin
            errors++;
            $display("FAIL reset_model p=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", cyc - 1, an, seg, dp, retire_cnt, exp_an, exp_seg, exp_dp, exp_ret);
         end
      end
   endtask

   task automatic test_valid_decode();
      logic [6:0] want [4];
      want[0] = 7'b0001000; want[1] = 7'b0100100; want[2] = 7'b0011001; want[3] = 7'b1111001;
      state = 4'hA; insn_type = 4'd1; insn_code = 4'd4; insn_stage = 3'd2;
      do tick(); while (cyc % FRAME != 0);
      for (int k = 0; k < FRAME; k++) begin
         tick();
         checks++;
         if (seg !== want[cur_d]) begin
            errors++;
            $display("FAIL valid_decode digit=%0d seg=%b want %b", cur_d, seg, want[cur_d]);
         end
         checks++;
         if ({an, seg, dp, retire_cnt} !== {exp_an, exp_seg, exp_dp, exp_ret}) begin
            errors++;
            $display("FAIL decode_model p=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", cyc - 1, an, seg, dp, retire_cnt, exp_an, exp_seg, exp_dp, exp_ret);
         end
      end
   endtask

   task automatic test_snapshot_isolation();
      for (int k = 0; k < 2 * FRAME; k++) begin
         tick();
         if (k == 4) insn_code = 4'd5;
         checks++;
         if (cur_d == 2 && seg !== ((k < FRAME) ? 7'b0011001 : 7'b0010010)) begin
            errors++;
            $display("FAIL snapshot_isolation k=%0d seg=%b", k, seg);
         end
         checks++;
         if ({an, seg, dp, retire_cnt} !== {exp_an, exp_seg, exp_dp, exp_ret}) begin
            errors++;
            $display("FAIL isolation_model p=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", cyc - 1, an, seg, dp, retire_cnt, exp_an, exp_seg, exp_dp, exp_ret);
         end
      end
   endtask

   task automatic test_invalid_blink();
      logic [6:0] dig3 [4];
      state = 4'd3; insn_type = 4'd9; insn_code = 4'd3; insn_stage = 3'd1;
      repeat (FRAME) tick();
      for (int k = 0; k < 4 * FRAME; k++) begin
         tick();
         if (cur_d == 3) dig3[k / FRAME] = seg;
         checks++;
         if ({an, seg, dp, retire_cnt} !== {exp_an, exp_seg, exp_dp, exp_ret}) begin
            errors++;
            $display("FAIL blink_model p=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", cyc - 1, an, seg, dp, retire_cnt, exp_an, exp_seg, exp_dp, exp_ret);
         end
      end
      checks++;
      if (!(dig3[1] === dig3[2] && dig3[0] === dig3[3] && dig3[0] !== dig3[1]
            && (dig3[0] === DASH || dig3[0] === BLANK) && (dig3[1] === DASH || dig3[1] === BLANK))) begin
         errors++;
         $display("FAIL blink_pattern frames=%b %b %b %b want two-frame dash/blank alternation", dig3[0], dig3[1], dig3[2], dig3[3]);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 40 * FRAME; k++) begin
         if ($urandom_range(7) == 0) begin
            state = 4'($urandom); insn_type = 4'($urandom);
            insn_code = 4'($urandom); insn_stage = 3'($urandom);
         end
         tick();
         checks++;
         if ({an, seg, dp, retire_cnt} !== {exp_an, exp_seg, exp_dp, exp_ret}) begin
            errors++;
            $display("FAIL random_model p=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", cyc - 1, an, seg, dp, retire_cnt, exp_an, exp_seg, exp_dp, exp_ret);
         end
      end
   endtask

   task automatic test_retire();
      logic [2:0] seq [4];
      logic [7:0] start;
      seq[0] = 3'd1; seq[1] = 3'd2; seq[2] = 3'd4; seq[3] = 3'd0;
      insn_type = 4'd3; insn_code = 4'd1;
      while (cyc % FRAME != 0) tick();
      insn_stage = 3'd0;
      repeat (2 * FRAME) tick();
      start = m_retire;
      for (int r = 0; r < 256; r++) begin
         for (int s = 0; s < 4; s++) begin
            insn_stage = seq[s];
            state = 4'($urandom);
            for (int k = 0; k < FRAME; k++) begin
               tick();
               checks++;
               if ({an, seg, dp, retire_cnt} !== {exp_an, exp_seg, exp_dp, exp_ret}) begin
                  errors++;
                  $display("FAIL retire_model p=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", cyc - 1, an, seg, dp, retire_cnt, exp_an, exp_seg, exp_dp, exp_ret);
               end
            end
         end
         if (r == 0) begin
            checks++;
            if (retire_cnt !== start + 8'd1) begin
               errors++;
               $display("FAIL retire_first got=%0d want=%0d", retire_cnt, start + 8'd1);
            end
         end
      end
      checks++;
      if (retire_cnt !== start) begin
         errors++;
         $display("FAIL retire_wrap got=%0d want=%0d", retire_cnt, start);
      end
   endtask

   task automatic test_async_reset();
      state = 4'd2; insn_type = 4'd1; insn_code = 4'd3;
      @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0; model_reset();
      for (int r = 0; r < 5; r++) begin
         insn_stage = 3'd1; repeat (FRAME) tick();
         insn_stage = 3'd0; repeat (FRAME) tick();
      end
      repeat (9) tick();
      checks++;
      if (retire_cnt !== 8'd5 || an !== 4'b1011) begin
         errors++;
         $display("FAIL async_setup ret=%0d an=%b want 5/1011", retire_cnt, an);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({an, seg, dp, retire_cnt} !== {4'b1111, 7'b1111111, 1'b1, 8'd0}) begin
         errors++;
         $display("FAIL async_reset an=%b seg=%b dp=%b ret=%0d want 1111/1111111/1/0", an, seg, dp, retire_cnt);
      end
      @(negedge clk); rst = 1'b0; model_reset();
      tick();
      checks++;
      if (an !== 4'b1110 || seg !== 7'b1000000) begin
         errors++;
         $display("FAIL async_restart an=%b seg=%b want 1110/1000000", an, seg);
      end
   endtask

   initial begin
      test_reset();
      test_valid_decode();
      test_snapshot_isolation();
      test_invalid_blink();
      test_random();
      test_retire();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
